// File: rtl/alu_cdb_stage_pkg.sv
// Shared definitions for the ALU functional unit and its CDB interface.
// Also used by the CDB arbiter and ROB.
package alu_cdb_stage_pkg;

  localparam int XLEN      = 32;
  localparam int CDB_TAG_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_func_e;

  typedef struct packed {
    logic                 valid;
    logic [CDB_TAG_W-1:0] tag;
    logic [XLEN-1:0]      value;
  } cdb_packet_t;

  localparam logic [XLEN-1:0] ALU_DEFAULT_RESULT = 32'hfacebeec;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; unknown function codes yield a recognisable marker value.
module alu
  import alu_cdb_stage_pkg::*;
(
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  alu_func_e       func,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = opb[4:0];

  always_comb begin
    result = ALU_DEFAULT_RESULT;
    case (func)
      ALU_ADD:  result = opa + opb;
      ALU_SUB:  result = opa - opb;
      ALU_AND:  result = opa & opb;
      ALU_OR:   result = opa | opb;
      ALU_XOR:  result = opa ^ opb;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, opa < opb};
      ALU_SLL:  result = opa << shamt;
      ALU_SRL:  result = opa >> shamt;
      ALU_SRA:  result = XLEN'($signed(opa) >>> shamt);
      default:  result = ALU_DEFAULT_RESULT;
    endcase
  end

endmodule

// File: rtl/result_fifo.sv
// In-order synchronous FIFO with occupancy count and first-word-fall-through head.
module result_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [PTR_W-1:0] head_next, tail_next;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  // Guard against overflow/underflow even if a caller misbehaves.
  assign do_pop  = pop & (count_reg != '0);
  assign do_push = push & ((count_reg < CNT_W'(DEPTH)) | do_pop);

  // Non-power-of-two depths need an explicit wrap.
  assign head_next = (head_reg == PTR_W'(DEPTH - 1)) ? '0 : head_reg + PTR_W'(1);
  assign tail_next = (tail_reg == PTR_W'(DEPTH - 1)) ? '0 : tail_reg + PTR_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (clear) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_next;
      if (do_pop)  head_reg <= head_next;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[tail_reg] <= wdata;
  end

  assign rdata = mem[head_reg];
  assign count = count_reg;

endmodule

// File: rtl/alu_cdb_stage.sv
// ALU execute stage: evaluates issued ops, buffers (tag, result) in order and
// broadcasts them on the CDB as grants arrive.
module alu_cdb_stage
  import alu_cdb_stage_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = 5,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [XLEN-1:0]  issue_opa,
  input  logic [XLEN-1:0]  issue_opb,
  input  alu_func_e        issue_func,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [XLEN-1:0]  cdb_value,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [CNT_W-1:0] count
);

  localparam int ENTRY_W = TAG_W + XLEN;

  logic [XLEN-1:0]    alu_result;
  logic [ENTRY_W-1:0] head_entry;
  logic [TAG_W-1:0]   head_tag;
  logic [XLEN-1:0]    head_value;
  logic               granted, push, pop;

  alu u_alu (
    .opa    (issue_opa),
    .opb    (issue_opb),
    .func   (issue_func),
    .result (alu_result)
  );

  assign cdb_req     = (count != '0);
  assign granted     = cdb_req & cdb_grant;
  // A slot freed by this cycle's grant can be refilled in the same cycle.
  assign issue_ready = (count < CNT_W'(DEPTH)) | granted;
  assign push        = issue_valid & issue_ready & ~flush;
  assign pop         = granted & ~flush;

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_result_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (push),
    .pop     (pop),
    .wdata   ({issue_tag, alu_result}),
    .rdata   (head_entry),
    .count   (count)
  );

  assign {head_tag, head_value} = head_entry;
  assign cdb_value = cdb_req ? head_value : '0;
  assign cdb_tag   = cdb_req ? head_tag   : '0;

endmodule
